// File: rtl/ram_bus_arbiter.sv
// ram_bus_arbiter: owns the shared 8-bit RAM bus and shares it round-robin
// between requester A (processor) and requester B (peripheral DMA).
// Every transaction returns through IDLE, where the bus address is parked,
// so the RAM has released BUS_DATA before the arbiter can drive it again.
module ram_bus_arbiter #(
  parameter logic [7:0] PARK_ADDR = 8'hFF
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       A_REQ,
  input  logic       A_WE,
  input  logic [7:0] A_ADDR,
  input  logic [7:0] A_WDATA,
  output logic       A_ACK,
  output logic [7:0] A_RDATA,
  input  logic       B_REQ,
  input  logic       B_WE,
  input  logic [7:0] B_ADDR,
  input  logic [7:0] B_WDATA,
  output logic       B_ACK,
  output logic [7:0] B_RDATA,
  output logic [7:0] BUS_ADDR,
  output logic       BUS_WE,
  inout  logic [7:0] BUS_DATA
);

  typedef enum logic [1:0] {IDLE, WRITE, RD_ADDR, RD_DATA} state_t;

  state_t     state;
  logic       owner_b;       // 1 = current transaction belongs to B
  logic       last_grant_b;  // 1 = B received the most recent grant
  logic       drive_en;      // arbiter drives BUS_DATA (WRITE only)
  logic [7:0] wdata_q;

  logic       grant_a;
  logic       grant_b;
  logic       sel_we;
  logic [7:0] sel_addr;
  logic [7:0] sel_wdata;

  // Round-robin choice: on contention the requester not granted last time wins
  always_comb begin
    grant_a   = A_REQ && (!B_REQ || last_grant_b);
    grant_b   = B_REQ && (!A_REQ || !last_grant_b);
    sel_we    = grant_b ? B_WE    : A_WE;
    sel_addr  = grant_b ? B_ADDR  : A_ADDR;
    sel_wdata = grant_b ? B_WDATA : A_WDATA;
  end

  assign BUS_DATA = drive_en ? wdata_q : 'z;

  // Transaction sequencer with registered bus and handshake outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= IDLE;
      owner_b      <= 1'b0;
      last_grant_b <= 1'b1;
      drive_en     <= 1'b0;
      wdata_q      <= '0;
      BUS_ADDR     <= PARK_ADDR;
      BUS_WE       <= 1'b0;
      A_ACK        <= 1'b0;
      B_ACK        <= 1'b0;
      A_RDATA      <= '0;
      B_RDATA      <= '0;
    end else begin
      A_ACK <= 1'b0;
      B_ACK <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_a || grant_b) begin
            owner_b      <= grant_b;
            last_grant_b <= grant_b;
            BUS_ADDR     <= sel_addr;
            wdata_q      <= sel_wdata;
            if (sel_we) begin
              state    <= WRITE;
              BUS_WE   <= 1'b1;
              drive_en <= 1'b1;
            end else begin
              state <= RD_ADDR;
            end
          end
        end
        WRITE: begin
          state    <= IDLE;
          BUS_ADDR <= PARK_ADDR;
          BUS_WE   <= 1'b0;
          drive_en <= 1'b0;
          if (owner_b) B_ACK <= 1'b1;
          else         A_ACK <= 1'b1;
        end
        RD_ADDR: begin
          state <= RD_DATA;
        end
        RD_DATA: begin
          state    <= IDLE;
          BUS_ADDR <= PARK_ADDR;
          if (owner_b) begin
            B_RDATA <= BUS_DATA;
            B_ACK   <= 1'b1;
          end else begin
            A_RDATA <= BUS_DATA;
            A_ACK   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Directed bench for ram_bus_arbiter with a small registered-output RAM
// on the shared bus (addresses 8'h00-8'h7F, one-cycle output enable lag).
module tb_ram_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_req, a_we, b_req, b_we;
  logic [7:0] a_addr, a_wdata, b_addr, b_wdata;
  logic       a_ack, b_ack;
  logic [7:0] a_rdata, b_rdata;
  logic [7:0] bus_addr;
  logic       bus_we;
  wire  [7:0] bus_data;

  logic       mem_init;
  logic [7:0] mem [0:127];
  logic       ram_oe = 1'b0;
  logic [7:0] ram_q  = 8'h00;

  int n_tests = 0;
  int n_fail  = 0;
  int contention = 0;
  int both_ack   = 0;

  always #5 clk = ~clk;

  ram_bus_arbiter #(.PARK_ADDR(8'hFF)) dut (
    .CLK(clk), .RESET(rst),
    .A_REQ(a_req), .A_WE(a_we), .A_ADDR(a_addr), .A_WDATA(a_wdata),
    .A_ACK(a_ack), .A_RDATA(a_rdata),
    .B_REQ(b_req), .B_WE(b_we), .B_ADDR(b_addr), .B_WDATA(b_wdata),
    .B_ACK(b_ack), .B_RDATA(b_rdata),
    .BUS_ADDR(bus_addr), .BUS_WE(bus_we), .BUS_DATA(bus_data)
  );

  // RAM model: output enable and data registered from the previous cycle's address
  assign bus_data = ram_oe ? ram_q : 8'hzz;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 128; i++) mem[i] <= 8'(i) ^ 8'h5A;
      ram_oe <= 1'b0;
    end else begin
      ram_oe <= (bus_addr < 8'h80) && !bus_we;
      ram_q  <= mem[bus_addr[6:0]];
      if (bus_we && (bus_addr < 8'h80)) mem[bus_addr[6:0]] <= bus_data;
    end
  end

  // Bus contention and double-ACK monitors
  always @(negedge clk) begin
    if (ram_oe && bus_we) contention++;
    if (a_ack && b_ack)   both_ack++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; mem_init = 1'b1;
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
    tick(); tick();
    mem_init = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_addr",    bus_addr, 8'hFF);
    chk("rst_we",      {7'd0, bus_we}, 8'h00);
    chk("rst_aack",    {7'd0, a_ack},  8'h00);
    chk("rst_back",    {7'd0, b_ack},  8'h00);
    chk("rst_ardata",  a_rdata, 8'h00);
    chk("rst_brdata",  b_rdata, 8'h00);

    // 1: A write 05<=3C then A read 05
    a_req = 1; a_we = 1; a_addr = 8'h05; a_wdata = 8'h3C;
    tick();
    chk("t1_w_addr",   bus_addr, 8'h05);
    chk("t1_w_we",     {7'd0, bus_we}, 8'h01);
    chk("t1_w_data",   bus_data, 8'h3C);
    chk("t1_w_noack",  {7'd0, a_ack},  8'h00);
    tick();
    chk("t1_w_ack",    {7'd0, a_ack},  8'h01);
    chk("t1_w_park",   bus_addr, 8'hFF);
    chk("t1_w_we0",    {7'd0, bus_we}, 8'h00);
    a_we = 0;
    tick();
    chk("t1_r_addr",   bus_addr, 8'h05);
    chk("t1_r_we",     {7'd0, bus_we}, 8'h00);
    chk("t1_r_noack1", {7'd0, a_ack},  8'h00);
    tick();
    chk("t1_r_noack2", {7'd0, a_ack},  8'h00);
    chk("t1_r_bus",    bus_data, 8'h3C);
    tick();
    chk("t1_r_ack",    {7'd0, a_ack},  8'h01);
    chk("t1_r_data",   a_rdata, 8'h3C);
    a_req = 0;
    tick();
    chk("t1_ack_pulse",{7'd0, a_ack},  8'h00);
    chk("t1_idle",     bus_addr, 8'hFF);

    // 2: simultaneous requests after reset, held: A,B,A,B
    rst = 1; tick(); rst = 0; tick();
    a_req = 1; a_we = 1; a_addr = 8'h20; a_wdata = 8'h11;
    b_req = 1; b_we = 1; b_addr = 8'h21; b_wdata = 8'h22;
    tick(); chk("t2_g1", bus_addr, 8'h20);
    tick(); chk("t2_ack1", {6'd0, a_ack, b_ack}, 8'h02);
    tick(); chk("t2_g2", bus_addr, 8'h21);
    tick(); chk("t2_ack2", {6'd0, a_ack, b_ack}, 8'h01);
    tick(); chk("t2_g3", bus_addr, 8'h20);
    tick(); chk("t2_ack3", {6'd0, a_ack, b_ack}, 8'h02);
    tick(); chk("t2_g4", bus_addr, 8'h21);
    tick(); chk("t2_ack4", {6'd0, a_ack, b_ack}, 8'h01);
    a_req = 0; b_req = 0;
    tick();
    chk("t2_mem20", mem[8'h20], 8'h11);
    chk("t2_mem21", mem[8'h21], 8'h22);

    // 3: B read 10 then A write 10<=AA, then B read 10 again
    b_req = 1; b_we = 0; b_addr = 8'h10;
    tick(); chk("t3_b_addr", bus_addr, 8'h10);
    a_req = 1; a_we = 1; a_addr = 8'h10; a_wdata = 8'hAA;
    tick();
    tick();
    chk("t3_b_ack",   {7'd0, b_ack}, 8'h01);
    chk("t3_b_data",  b_rdata, 8'h4A);
    chk("t3_gap_adr", bus_addr, 8'hFF);
    chk("t3_gap_we",  {7'd0, bus_we}, 8'h00);
    b_req = 0;
    tick();
    chk("t3_a_we",    {7'd0, bus_we}, 8'h01);
    chk("t3_a_data",  bus_data, 8'hAA);
    tick();
    chk("t3_a_ack",   {7'd0, a_ack}, 8'h01);
    a_req = 0;
    b_req = 1; b_we = 0; b_addr = 8'h10;
    tick(); tick(); tick();
    chk("t3_b2_ack",  {7'd0, b_ack}, 8'h01);
    chk("t3_b2_data", b_rdata, 8'hAA);
    b_req = 0;
    tick();

    // 4: reset during RD_DATA
    rst = 1; tick(); rst = 0; tick();
    a_req = 1; a_we = 0; a_addr = 8'h05;
    tick(); tick();
    rst = 1;
    tick();
    chk("t4_addr",   bus_addr, 8'hFF);
    chk("t4_we",     {7'd0, bus_we}, 8'h00);
    chk("t4_ack",    {6'd0, a_ack, b_ack}, 8'h00);
    chk("t4_rdata",  a_rdata, 8'h00);
    rst = 0; a_req = 0;
    tick();
    chk("t4_ack2",   {6'd0, a_ack, b_ack}, 8'h00);
    chk("t4_rdata2", a_rdata, 8'h00);

    // 5: A REQ dropped during RD_ADDR
    a_req = 1; a_we = 0; a_addr = 8'h21;
    tick();
    chk("t5_addr",   bus_addr, 8'h21);
    a_req = 0;
    tick();
    chk("t5_noack",  {7'd0, a_ack}, 8'h00);
    tick();
    chk("t5_ack",    {7'd0, a_ack}, 8'h01);
    chk("t5_rdata",  a_rdata, 8'h22);
    chk("t5_brdata", b_rdata, 8'h00);
    tick();
    chk("t5_ack_off",{7'd0, a_ack}, 8'h00);
    chk("t5_park1",  bus_addr, 8'hFF);
    tick();
    chk("t5_park2",  bus_addr, 8'hFF);
    chk("t5_ack_off2",{7'd0, a_ack}, 8'h00);

    // Whole-run monitors
    chk("no_contention", 8'(contention), 8'h00);
    chk("no_double_ack", 8'(both_ack),   8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
